// File: rtl/simon_pkg.sv
// Shared constants for the Simon game datapath and its controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package simon_pkg;

    localparam int PAT_W  = 4;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = $clog2(DEPTH);

    // LED mode encodings driven by the controller
    localparam logic [2:0] LED_MODE_INPUT    = 3'b001;
    localparam logic [2:0] LED_MODE_PLAYBACK = 3'b010;
    localparam logic [2:0] LED_MODE_REPEAT   = 3'b100;
    localparam logic [2:0] LED_MODE_DONE     = 3'b111;

    // True when exactly one bit of the pattern is set (zero is not one-hot)
    function automatic logic is_one_hot(input logic [PAT_W-1:0] p);
        return (p != '0) && ((p & (p - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/simon_pattern_mem.sv
// Pattern store: DEPTH x W array, synchronous write, asynchronous read.
// Latency: write lands on the clock edge; read is combinational.
// Backpressure: none; a write is accepted every cycle wr_en is high.
module simon_pattern_mem
    import simon_pkg::*;
#(
    parameter int W  = PAT_W,
    parameter int D  = DEPTH,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_dat
);

    logic [W-1:0] mem [D];

    // Storage is never reset so patterns survive a game restart
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/simon_datapath.sv
// Simon datapath: level register, pattern memory, write counter, playback index, flags.
// Latency: state updates on the clock edge; all outputs combinational (zero latency).
// Backpressure: none; the controller owns every enable. Option: SIMON_DATAPATH_SATURATE_EN.
module simon_datapath
    import simon_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             counter_rst,
    input  logic             current_rst,
    input  logic             level,
    input  logic             level_enable,
    input  logic [PAT_W-1:0] pattern,
    input  logic             write_enable,
    input  logic             counter_enable,
    input  logic             current_enable,
    input  logic             display_choice,
    output logic             pattern_valid,
    output logic             pattern_same,
    output logic             SeenAll,
    output logic [PAT_W-1:0] pattern_leds
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic              level_reg;
    logic [ADDR_W-1:0] counter;
    logic [ADDR_W-1:0] current;
    logic [ADDR_W-1:0] counter_nxt;
    logic [ADDR_W-1:0] current_nxt;
    logic [PAT_W-1:0]  mem_dat;

    // Index advance: saturate at the last entry or wrap back to zero
    always_comb begin
        counter_nxt = counter + 1'b1;
        current_nxt = current + 1'b1;
`ifdef SIMON_DATAPATH_SATURATE_EN
        if (counter == LAST_IDX) counter_nxt = counter;
        if (current == LAST_IDX) current_nxt = current;
`else
        if (counter == LAST_IDX) counter_nxt = '0;
        if (current == LAST_IDX) current_nxt = '0;
`endif
    end

    // Difficulty level only follows the switch while the controller enables it
    always_ff @(posedge clk) begin
        if (rst) begin
            level_reg <= 1'b0;
        end else if (level_enable) begin
            level_reg <= level;
        end
    end

    // Write counter: global reset, then local clear, then increment
    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
        end else if (counter_rst) begin
            counter <= '0;
        end else if (counter_enable) begin
            counter <= counter_nxt;
        end
    end

    // Playback index: global reset, then local clear, then increment
    always_ff @(posedge clk) begin
        if (rst) begin
            current <= '0;
        end else if (current_rst) begin
            current <= '0;
        end else if (current_enable) begin
            current <= current_nxt;
        end
    end

    // Write goes to the pre-increment counter value; read follows the playback index
    simon_pattern_mem #(
        .W  (PAT_W),
        .D  (DEPTH),
        .AW (ADDR_W)
    ) mem (
        .clk     (clk),
        .wr_en   (write_enable),
        .wr_addr (counter),
        .wr_dat  (pattern),
        .rd_addr (current),
        .rd_dat  (mem_dat)
    );

    // Flags and LED drive for the controller
    always_comb begin
        pattern_valid = level_reg ? is_one_hot(pattern) : 1'b1;
        pattern_same  = (pattern == mem_dat);
        SeenAll       = (current == counter);
        pattern_leds  = display_choice ? pattern : mem_dat;
    end

endmodule

// File: tb/tb_simon_datapath.sv
// Bench for simon_datapath: directed scenarios followed by randomized traffic.
// Expected values come from an array-based model of the game datapath.
// Unwritten memory entries are tracked so X reads are never compared.
module tb_simon_datapath;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       counter_rst = 1'b0;
    logic       current_rst = 1'b0;
    logic       level = 1'b0;
    logic       level_enable = 1'b0;
    logic [3:0] pattern = 4'b0000;
    logic       write_enable = 1'b0;
    logic       counter_enable = 1'b0;
    logic       current_enable = 1'b0;
    logic       display_choice = 1'b0;
    logic       pattern_valid;
    logic       pattern_same;
    logic       SeenAll;
    logic [3:0] pattern_leds;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int         m_lvl = 0;
    int         m_cnt = 0;
    int         m_cur = 0;
    logic [3:0] m_mem [64];
    bit         m_written [64];

    simon_datapath dut (
        .clk            (clk),
        .rst            (rst),
        .counter_rst    (counter_rst),
        .current_rst    (current_rst),
        .level          (level),
        .level_enable   (level_enable),
        .pattern        (pattern),
        .write_enable   (write_enable),
        .counter_enable (counter_enable),
        .current_enable (current_enable),
        .display_choice (display_choice),
        .pattern_valid  (pattern_valid),
        .pattern_same   (pattern_same),
        .SeenAll        (SeenAll),
        .pattern_leds   (pattern_leds)
    );

    always #5 clk = ~clk;

    function automatic int advance(input int idx);
`ifdef SIMON_DATAPATH_SATURATE_EN
        return (idx >= 63) ? 63 : idx + 1;
`else
        return (idx + 1) % 64;
`endif
    endfunction

    // One clock edge; model absorbs the inputs that were present at the edge
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_lvl = 0;
            m_cnt = 0;
            m_cur = 0;
        end else begin
            if (level_enable) m_lvl = int'(level);
            if (write_enable) begin
                m_mem[m_cnt]     = pattern;
                m_written[m_cnt] = 1'b1;
            end
            if (counter_rst) m_cnt = 0;
            else if (counter_enable) m_cnt = advance(m_cnt);
            if (current_rst) m_cur = 0;
            else if (current_enable) m_cur = advance(m_cur);
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Compare every output against the model, skipping reads of unwritten entries
    task automatic check_all(input string tag);
        logic       exp_valid;
        logic [3:0] exp_leds;
        #4;
        exp_valid = (m_lvl == 0) || ($countones(pattern) == 1);
        chk({tag, "_valid"}, {3'b000, pattern_valid}, {3'b000, exp_valid});
        chk({tag, "_seenall"}, {3'b000, SeenAll}, {3'b000, (m_cur == m_cnt)});
        if (m_written[m_cur]) begin
            exp_leds = display_choice ? pattern : m_mem[m_cur];
            chk({tag, "_same"}, {3'b000, pattern_same}, {3'b000, (pattern == m_mem[m_cur])});
            chk({tag, "_leds"}, pattern_leds, exp_leds);
        end else if (display_choice) begin
            chk({tag, "_leds"}, pattern_leds, pattern);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            m_written[i] = 1'b0;
            m_mem[i]     = 4'b0000;
        end

        // 1. reset state, easy mode accepts anything
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        pattern = 4'b0110;
        check_all("reset");
        chk("reset_seenall_const", {3'b000, SeenAll}, 4'b0001);
        chk("reset_easy_valid_const", {3'b000, pattern_valid}, 4'b0001);

        // 2. hard mode latched, switch released afterwards
        level = 1'b1;
        level_enable = 1'b1;
        tick();
        level = 1'b0;
        level_enable = 1'b0;
        pattern = 4'b0110;
        check_all("hard_0110");
        chk("hard_0110_const", {3'b000, pattern_valid}, 4'b0000);
        tick();
        pattern = 4'b0100;
        check_all("hard_0100");
        chk("hard_0100_const", {3'b000, pattern_valid}, 4'b0001);
        pattern = 4'b0000;
        tick();
        check_all("hard_0000");
        chk("hard_0000_const", {3'b000, pattern_valid}, 4'b0000);

        // 3. first write with simultaneous counter increment
        rst = 1'b1;
        tick();
        rst = 1'b0;
        write_enable = 1'b1;
        counter_enable = 1'b1;
        pattern = 4'b0010;
        tick();
        write_enable = 1'b0;
        counter_enable = 1'b0;
        display_choice = 1'b0;
        check_all("write0");
        chk("write0_leds_const", pattern_leds, 4'b0010);
        chk("write0_seenall_const", {3'b000, SeenAll}, 4'b0000);

        // 4. LED source select and equality flag
        pattern = 4'b0100;
        display_choice = 1'b1;
        check_all("disp_input");
        chk("disp_input_same_const", {3'b000, pattern_same}, 4'b0000);
        pattern = 4'b0010;
        check_all("same_match");
        chk("same_match_const", {3'b000, pattern_same}, 4'b0001);

        // 5. store two more entries, then play them back
        display_choice = 1'b0;
        write_enable = 1'b1;
        counter_enable = 1'b1;
        pattern = 4'b0100;
        tick();
        pattern = 4'b1000;
        tick();
        write_enable = 1'b0;
        counter_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            current_enable = 1'b1;
            tick();
            current_enable = 1'b0;
            check_all($sformatf("playback%0d", i));
            chk($sformatf("playback%0d_seenall_const", i), {3'b000, SeenAll},
                (i == 2) ? 4'b0001 : 4'b0000);
        end
        current_rst = 1'b1;
        tick();
        current_rst = 1'b0;
        check_all("current_rst");
        chk("current_rst_leds_const", pattern_leds, 4'b0010);

        // 6. counter wrap (or saturation), then reset mid-run keeps memory
        rst = 1'b1;
        tick();
        rst = 1'b0;
        counter_enable = 1'b1;
        for (int i = 0; i < 64; i++) tick();
        counter_enable = 1'b0;
        check_all("cnt64");
`ifdef SIMON_DATAPATH_SATURATE_EN
        chk("cnt64_seenall_const", {3'b000, SeenAll}, 4'b0000);
`else
        chk("cnt64_seenall_const", {3'b000, SeenAll}, 4'b0001);
`endif
        counter_enable = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        counter_enable = 1'b0;
        display_choice = 1'b0;
        check_all("midrun_rst");
        chk("midrun_rst_seenall_const", {3'b000, SeenAll}, 4'b0001);
        chk("midrun_rst_mem0_const", pattern_leds, 4'b0010);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 31) == 0);
            counter_rst    = ($urandom_range(0, 15) == 0);
            current_rst    = ($urandom_range(0, 15) == 0);
            level          = 1'($urandom);
            level_enable   = ($urandom_range(0, 3) == 0);
            pattern        = 4'($urandom);
            write_enable   = !rst && 1'($urandom);
            counter_enable = 1'($urandom);
            current_enable = 1'($urandom);
            display_choice = 1'($urandom);
            check_all("rand");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
